// File: rtl/shield_write_pkg.sv
// Shared constants, types and chunk arithmetic for the AXI write address splitter.
package shield_write_pkg;

  localparam int unsigned CL_ID_WIDTH         = 6;
  localparam int unsigned CL_ADDR_WIDTH       = 64;
  localparam int unsigned CL_DATA_WIDTH       = 64;
  localparam int unsigned OFFSET_WIDTH        = 6;
  localparam int unsigned BURSTS_PER_LINE     = 8;
  localparam int unsigned BURSTS_PER_LINE_LOG = 3;

  localparam int unsigned BEAT_BYTES_LOG   = $clog2(CL_DATA_WIDTH / 8);
  localparam int unsigned WORD_ADDR_WIDTH  = CL_ADDR_WIDTH - BEAT_BYTES_LOG;
  localparam int unsigned LINE_INDEX_WIDTH = WORD_ADDR_WIDTH - BURSTS_PER_LINE_LOG;
  localparam int unsigned BEATS_WIDTH      = 9;
  localparam int unsigned CNT_WIDTH        = 6;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SPLIT       = 2'd1,
    ST_WAIT_COMMIT = 2'd2,
    ST_RESP        = 2'd3
  } state_t;

  typedef struct packed {
    logic [CL_ADDR_WIDTH-1:0] line_addr;
    logic [7:0]               count;
    logic [OFFSET_WIDTH-1:0]  offset;
  } line_req_t;

  // Carve the next line-sized chunk from a beat address and the beats still owed.
  function automatic line_req_t next_chunk(input logic [WORD_ADDR_WIDTH-1:0] addr,
                                           input logic [BEATS_WIDTH-1:0] beats_left);
    logic [BURSTS_PER_LINE_LOG-1:0] b;
    logic [BEATS_WIDTH-1:0]         room;
    line_req_t                      r;
    b           = addr[BURSTS_PER_LINE_LOG-1:0];
    room        = BEATS_WIDTH'(BURSTS_PER_LINE) - BEATS_WIDTH'(b);
    r.line_addr = {addr[WORD_ADDR_WIDTH-1:BURSTS_PER_LINE_LOG], OFFSET_WIDTH'(0)};
    r.count     = (beats_left < room) ? 8'(beats_left) : 8'(room);
    r.offset    = {b, BEAT_BYTES_LOG'(0)};
    return r;
  endfunction

endpackage

// File: rtl/shield_write_addr_split_if.sv
// AXI AW/B channels plus the line-request and commit side of the splitter.
interface shield_write_addr_split_if;
  import shield_write_pkg::*;

  logic [CL_ID_WIDTH-1:0]   s_axi_awid;
  logic [CL_ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0]               s_axi_awlen;
  logic [2:0]               s_axi_awsize;
  logic [1:0]               s_axi_awburst;
  logic                     s_axi_awvalid;
  logic                     s_axi_awready;

  logic [CL_ADDR_WIDTH-1:0] req_line_addr;
  logic [7:0]               burst_count;
  logic [OFFSET_WIDTH-1:0]  burst_start_offset;
  logic                     req_val;
  logic                     req_rdy;
  logic                     line_commit;

  logic [CL_ID_WIDTH-1:0]   s_axi_bid;
  logic [1:0]               s_axi_bresp;
  logic                     s_axi_bvalid;
  logic                     s_axi_bready;

  // Splitter side
  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    output req_line_addr, burst_count, burst_start_offset, req_val,
    input  req_rdy, line_commit,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready
  );

  // Upstream master and downstream line-write path
  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    input  req_line_addr, burst_count, burst_start_offset, req_val,
    output req_rdy, line_commit,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready
  );

endinterface

// File: rtl/shield_write_addr_split.sv
// Splits one AXI4 AW burst into per-line write requests and returns one B after all lines commit.
module shield_write_addr_split
  import shield_write_pkg::*;
(
  input logic                      clk,
  input logic                      rst_n,
  shield_write_addr_split_if.slave io_bus
);

  state_t                     r_state;
  logic [CL_ID_WIDTH-1:0]     r_id;
  logic [WORD_ADDR_WIDTH-1:0] r_addr;
  logic [BEATS_WIDTH-1:0]     r_beats_left;
  logic                       r_err;
  logic [CNT_WIDTH-1:0]       r_lines_issued;
  logic [CNT_WIDTH-1:0]       r_commits;
  logic                       r_awready;
  line_req_t                  r_req;
  logic                       r_req_val;
  logic [CL_ID_WIDTH-1:0]     r_bid;
  logic [1:0]                 r_bresp;
  logic                       r_bvalid;

  logic                       w_aw_hs;
  logic                       w_req_hs;
  logic [WORD_ADDR_WIDTH-1:0] w_aw_word;
  logic [BEATS_WIDTH-1:0]     w_aw_beats;
  logic                       w_aw_err;
  line_req_t                  w_first;
  logic [BEATS_WIDTH-1:0]     w_beats_after;
  logic [WORD_ADDR_WIDTH-1:0] w_addr_next;
  line_req_t                  w_next;
  logic                       w_unused_ok;

  // Handshakes and chunk arithmetic for the first and following lines
  assign w_aw_hs       = io_bus.s_axi_awvalid & r_awready;
  assign w_req_hs      = r_req_val & io_bus.req_rdy;
  assign w_aw_word     = io_bus.s_axi_awaddr[CL_ADDR_WIDTH-1:BEAT_BYTES_LOG];
  assign w_aw_beats    = {1'b0, io_bus.s_axi_awlen} + BEATS_WIDTH'(1);
  assign w_aw_err      = (io_bus.s_axi_awsize != 3'(BEAT_BYTES_LOG)) ||
                         (io_bus.s_axi_awburst != AXI_BURST_INCR);
  assign w_first       = next_chunk(w_aw_word, w_aw_beats);
  assign w_beats_after = r_beats_left - BEATS_WIDTH'(r_req.count);
  assign w_addr_next   = {r_addr[WORD_ADDR_WIDTH-1:BURSTS_PER_LINE_LOG] + LINE_INDEX_WIDTH'(1),
                          BURSTS_PER_LINE_LOG'(0)};
  assign w_next        = next_chunk(w_addr_next, w_beats_after);

  // Sub-beat address bits are truncated by design
  assign w_unused_ok   = ^io_bus.s_axi_awaddr[BEAT_BYTES_LOG-1:0];

  // Transaction FSM, line/commit counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_id           <= '0;
      r_addr         <= '0;
      r_beats_left   <= '0;
      r_err          <= 1'b0;
      r_lines_issued <= '0;
      r_commits      <= '0;
      r_awready      <= 1'b0;
      r_req          <= '0;
      r_req_val      <= 1'b0;
      r_bid          <= '0;
      r_bresp        <= '0;
      r_bvalid       <= 1'b0;
    end else begin
      if ((r_state != ST_IDLE) && io_bus.line_commit) begin
        r_commits <= r_commits + CNT_WIDTH'(1);
      end
      case (r_state)
        ST_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_id           <= io_bus.s_axi_awid;
            r_addr         <= w_aw_word;
            r_beats_left   <= w_aw_beats;
            r_err          <= w_aw_err;
            r_lines_issued <= '0;
            r_commits      <= '0;
            r_awready      <= 1'b0;
            r_req          <= w_first;
            r_req_val      <= 1'b1;
            r_state        <= ST_SPLIT;
          end
        end
        ST_SPLIT: begin
          if (w_req_hs) begin
            r_lines_issued <= r_lines_issued + CNT_WIDTH'(1);
            r_beats_left   <= w_beats_after;
            r_addr         <= w_addr_next;
            if (w_beats_after == '0) begin
              r_req_val <= 1'b0;
              r_state   <= ST_WAIT_COMMIT;
            end else begin
              r_req <= w_next;
            end
          end
        end
        ST_WAIT_COMMIT: begin
          if (r_commits == r_lines_issued) begin
            r_bid    <= r_id;
            r_bresp  <= r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            r_bvalid <= 1'b1;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (io_bus.s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.s_axi_awready      = r_awready;
  assign io_bus.req_line_addr      = r_req.line_addr;
  assign io_bus.burst_count        = r_req.count;
  assign io_bus.burst_start_offset = r_req.offset;
  assign io_bus.req_val            = r_req_val;
  assign io_bus.s_axi_bid          = r_bid;
  assign io_bus.s_axi_bresp        = r_bresp;
  assign io_bus.s_axi_bvalid       = r_bvalid;

endmodule

// File: tb/tb_shield_write_addr_split.sv
// Directed bench for shield_write_addr_split: splitting, stalls, commit counting, errors, reset abort.
module tb_shield_write_addr_split;
  import shield_write_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shield_write_addr_split_if bus_if ();

  shield_write_addr_split dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one AW once awready is seen; returns at the negedge after the handshake
  task automatic send_aw(input string tag, input logic [5:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    for (int i = 0; i < 20 && !bus_if.s_axi_awready; i++) @(negedge clk);
    chk({tag, "_awready"}, 64'(bus_if.s_axi_awready), 64'd1);
    bus_if.s_axi_awid    = id;
    bus_if.s_axi_awaddr  = addr;
    bus_if.s_axi_awlen   = len;
    bus_if.s_axi_awsize  = 3'd3;
    bus_if.s_axi_awburst = burst;
    bus_if.s_axi_awvalid = 1'b1;
    @(negedge clk);
    bus_if.s_axi_awvalid = 1'b0;
    chk({tag, "_awready_low"}, 64'(bus_if.s_axi_awready), 64'd0);
  endtask

  // Check the presented chunk and accept it in one cycle, optionally with a same-cycle commit
  task automatic take_req(input string tag, input logic [63:0] ea, input logic [7:0] ec,
                          input logic [5:0] eo, input logic commit_same);
    for (int i = 0; i < 20 && !bus_if.req_val; i++) @(negedge clk);
    chk({tag, "_val"}, 64'(bus_if.req_val), 64'd1);
    chk({tag, "_addr"}, bus_if.req_line_addr, ea);
    chk({tag, "_cnt"}, 64'(bus_if.burst_count), 64'(ec));
    chk({tag, "_off"}, 64'(bus_if.burst_start_offset), 64'(eo));
    bus_if.req_rdy     = 1'b1;
    bus_if.line_commit = commit_same;
    @(negedge clk);
    bus_if.req_rdy     = 1'b0;
    bus_if.line_commit = 1'b0;
  endtask

  task automatic commit_pulse();
    bus_if.line_commit = 1'b1;
    @(negedge clk);
    bus_if.line_commit = 1'b0;
  endtask

  // Wait for B, check it, accept it, then confirm the return to idle
  task automatic expect_b(input string tag, input logic [5:0] id, input logic [1:0] resp);
    for (int i = 0; i < 20 && !bus_if.s_axi_bvalid; i++) @(negedge clk);
    chk({tag, "_bvalid"}, 64'(bus_if.s_axi_bvalid), 64'd1);
    chk({tag, "_bid"}, 64'(bus_if.s_axi_bid), 64'(id));
    chk({tag, "_bresp"}, 64'(bus_if.s_axi_bresp), 64'(resp));
    bus_if.s_axi_bready = 1'b1;
    @(negedge clk);
    bus_if.s_axi_bready = 1'b0;
    chk({tag, "_bvalid_clr"}, 64'(bus_if.s_axi_bvalid), 64'd0);
    chk({tag, "_awready_back"}, 64'(bus_if.s_axi_awready), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 64'(bus_if.s_axi_awready), 64'd0);
    chk({tag, "_req_val"}, 64'(bus_if.req_val), 64'd0);
    chk({tag, "_line_addr"}, bus_if.req_line_addr, 64'd0);
    chk({tag, "_cnt"}, 64'(bus_if.burst_count), 64'd0);
    chk({tag, "_off"}, 64'(bus_if.burst_start_offset), 64'd0);
    chk({tag, "_bvalid"}, 64'(bus_if.s_axi_bvalid), 64'd0);
    chk({tag, "_bid"}, 64'(bus_if.s_axi_bid), 64'd0);
    chk({tag, "_bresp"}, 64'(bus_if.s_axi_bresp), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n                = 1'b0;
    bus_if.s_axi_awid    = '0;
    bus_if.s_axi_awaddr  = '0;
    bus_if.s_axi_awlen   = '0;
    bus_if.s_axi_awsize  = 3'd3;
    bus_if.s_axi_awburst = AXI_BURST_INCR;
    bus_if.s_axi_awvalid = 1'b0;
    bus_if.req_rdy       = 1'b0;
    bus_if.line_commit   = 1'b0;
    bus_if.s_axi_bready  = 1'b0;

    // Reset state and awready rising one clock after release
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    #1;
    chk("rst_rel_awready_0", 64'(bus_if.s_axi_awready), 64'd0);
    @(negedge clk);
    chk("rst_rel_awready_1", 64'(bus_if.s_axi_awready), 64'd1);

    // 1: single beat at line 0
    send_aw("t1_aw", 6'h05, 64'h0, 8'd0, AXI_BURST_INCR);
    take_req("t1_r0", 64'h0, 8'd1, 6'h00, 1'b0);
    chk("t1_req_val_drop", 64'(bus_if.req_val), 64'd0);
    chk("t1_awready_wait", 64'(bus_if.s_axi_awready), 64'd0);
    commit_pulse();
    expect_b("t1_b", 6'h05, AXI_RESP_OKAY);

    // 2: three beats inside one line
    send_aw("t2_aw", 6'h11, 64'h8, 8'd2, AXI_BURST_INCR);
    take_req("t2_r0", 64'h0, 8'd3, 6'h08, 1'b0);
    commit_pulse();
    expect_b("t2_b", 6'h11, AXI_RESP_OKAY);

    // 3: two beats straddling a line boundary; B only after both commits
    send_aw("t3_aw", 6'h22, 64'h38, 8'd1, AXI_BURST_INCR);
    take_req("t3_r0", 64'h0, 8'd1, 6'h38, 1'b0);
    take_req("t3_r1", 64'h40, 8'd1, 6'h00, 1'b0);
    commit_pulse();
    repeat (4) @(negedge clk);
    chk("t3_no_early_b", 64'(bus_if.s_axi_bvalid), 64'd0);
    commit_pulse();
    expect_b("t3_b", 6'h22, AXI_RESP_OKAY);

    // 4: sixteen beats from 0x10 with a three-cycle stall on the second chunk
    send_aw("t4_aw", 6'h33, 64'h10, 8'd15, AXI_BURST_INCR);
    take_req("t4_r0", 64'h0, 8'd6, 6'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_val", 64'(bus_if.req_val), 64'd1);
      chk("t4_stall_addr", bus_if.req_line_addr, 64'h40);
      chk("t4_stall_cnt", 64'(bus_if.burst_count), 64'd8);
      chk("t4_stall_off", 64'(bus_if.burst_start_offset), 64'd0);
      @(negedge clk);
    end
    take_req("t4_r1", 64'h40, 8'd8, 6'h00, 1'b0);
    take_req("t4_r2", 64'h80, 8'd2, 6'h00, 1'b0);
    chk("t4_awready_split", 64'(bus_if.s_axi_awready), 64'd0);
    commit_pulse();
    commit_pulse();
    chk("t4_awready_wait", 64'(bus_if.s_axi_awready), 64'd0);
    commit_pulse();
    expect_b("t4_b", 6'h33, AXI_RESP_OKAY);

    // 5: FIXED burst still split as INCR, SLVERR; commit lands with the req handshake
    send_aw("t5_aw", 6'h3f, 64'h100, 8'd7, 2'b00);
    take_req("t5_r0", 64'h100, 8'd8, 6'h00, 1'b1);
    expect_b("t5_b", 6'h3f, AXI_RESP_SLVERR);

    // 6: reset in the middle of a split aborts with no B
    send_aw("t6_aw", 6'h07, 64'h0, 8'd15, AXI_BURST_INCR);
    take_req("t6_r0", 64'h0, 8'd8, 6'h00, 1'b0);
    chk("t6_mid_split", 64'(bus_if.req_val), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_awready_0", 64'(bus_if.s_axi_awready), 64'd0);
    @(negedge clk);
    chk("t6_rel_awready_1", 64'(bus_if.s_axi_awready), 64'd1);
    bus_if.line_commit = 1'b1;
    repeat (5) @(negedge clk);
    bus_if.line_commit = 1'b0;
    chk("t6_no_b", 64'(bus_if.s_axi_bvalid), 64'd0);
    chk("t6_no_req", 64'(bus_if.req_val), 64'd0);

    // 7: sub-beat address bits are dropped
    send_aw("t7_aw", 6'h2a, 64'h45, 8'd0, AXI_BURST_INCR);
    take_req("t7_r0", 64'h40, 8'd1, 6'h00, 1'b0);
    commit_pulse();
    expect_b("t7_b", 6'h2a, AXI_RESP_OKAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute runtime bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
